// File: rtl/nioslab2_mem_stream_reader_pkg.sv
// Shared types and constants for the on-chip memory stream reader.
// The read tag travels with each outstanding read so sop/eop land in the FIFO beside the data.
package niosLab2_mem_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] MEM_BE_ALL     = 4'hF;
    localparam int         MEM_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic vld;
        logic sop;
        logic eop;
    } rd_tag_t;

endpackage

// File: rtl/nioslab2_mem_stream_reader_fifo.sv
// Synchronous FIFO holding {sop, eop, data} beats for the stream source.
// Head data is forced to zero while empty so the stream outputs idle at zero.
module niosLab2_stream_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 34,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_rd;

    always_comb begin
        do_rd    = rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/nioslab2_mem_stream_reader.sv
// Avalon-MM read master streaming a block of on-chip RAM words out of an Avalon-ST source.
//   state | meaning
//   IDLE  | waiting for start; first read is issued on the accepting edge
//   RUN   | issuing one read per cycle while FIFO credit allows
//   DRAIN | all reads issued; waiting for the eop beat to hand off
module nioslab2_mem_stream_reader
    import niosLab2_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_startofpacket,
    output logic              st_endofpacket
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    rd_tag_t           cs_tag_q, cs_tag_d;
    rd_tag_t [MEM_RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

    rd_tag_t           arr_tag;
    logic [DATA_W+1:0] fifo_rdata;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              pop;
    logic [OCC_W-1:0]  occ;
    logic              credit_ok;

    assign arr_tag = rd_pipe_q[MEM_RD_LATENCY-1];

    niosLab2_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (arr_tag.vld),
        .wr_data ({arr_tag.sop, arr_tag.eop, mem_readdata}),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign st_valid         = ~fifo_empty;
    assign st_startofpacket = fifo_rdata[DATA_W+1];
    assign st_endofpacket   = fifo_rdata[DATA_W];
    assign st_data          = fifo_rdata[DATA_W-1:0];
    assign pop              = st_valid & st_ready;

    // Slots already committed after this cycle: stored beats, data landing now,
    // and the read on the bus this cycle. One more read is allowed only if a slot remains.
    always_comb begin
        occ = {1'b0, fifo_count} + {{CNT_W{1'b0}}, cs_tag_q.vld};
        for (int i = 0; i < MEM_RD_LATENCY; i++) begin
            occ = occ + {{CNT_W{1'b0}}, rd_pipe_q[i].vld};
        end
        occ       = occ - {{CNT_W{1'b0}}, pop};
        credit_ok = (occ < OCC_W'(FIFO_DEPTH));
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        remain_d    = remain_q;
        cs_tag_d    = '0;
        rd_pipe_d[0] = cs_tag_q;
        for (int i = 1; i < MEM_RD_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = RUN;
                        busy_d       = 1'b1;
                        cs_tag_d.vld = 1'b1;
                        cs_tag_d.sop = 1'b1;
                        cs_tag_d.eop = (length == LEN_ONE);
                        addr_d       = start_addr;
                        next_addr_d  = start_addr + ADDR_ONE;
                        remain_d     = length - LEN_ONE;
                    end
                end
            end
            RUN: begin
                if (remain_q == '0) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    cs_tag_d.vld = 1'b1;
                    cs_tag_d.eop = (remain_q == LEN_ONE);
                    addr_d       = next_addr_q;
                    next_addr_d  = next_addr_q + ADDR_ONE;
                    remain_d     = remain_q - LEN_ONE;
                end
            end
            DRAIN: begin
                if (pop && st_endofpacket) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            next_addr_q <= '0;
            remain_q    <= '0;
            cs_tag_q    <= '0;
            rd_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            remain_q    <= remain_d;
            cs_tag_q    <= cs_tag_d;
            rd_pipe_q   <= rd_pipe_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_address    = addr_q;
    assign mem_chipselect = cs_tag_q.vld;
    assign mem_write      = 1'b0;
    assign mem_byteenable = MEM_BE_ALL;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_nioslab2_mem_stream_reader.sv
// Scoreboard bench for the memory stream reader: RAM model holds word[i]=i,
// start issues push expected beats/done cycles, a negedge monitor pops and compares.
module tb_nioslab2_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [13:0] start_addr;
    logic [14:0] length;
    logic        busy, done;
    logic [13:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [31:0] st_data;
    logic        st_valid, st_ready, st_startofpacket, st_endofpacket;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        int          cyc;
    } beat_t;

    beat_t       sb[$];
    int          done_exp[$];
    logic [31:0] mem [16384];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int rd_cnt = 0, beat_cnt = 0, val_cnt = 0, done_cnt = 0, max_out = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_sop, prev_eop;

    nioslab2_mem_stream_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .mem_address      (mem_address),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_byteenable   (mem_byteenable),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .st_startofpacket (st_startofpacket),
        .st_endofpacket   (st_endofpacket)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem[mem_address];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            beat_t e;
            if (mem_chipselect) rd_cnt++;
            if (st_valid) val_cnt++;
            if (prev_stall) begin
                chk("hold_valid", st_valid, 1);
                chk("hold_data", st_data, prev_data);
                chk("hold_sop", st_startofpacket, prev_sop);
                chk("hold_eop", st_endofpacket, prev_eop);
            end
            if (st_valid && st_ready) begin
                beat_cnt++;
                if (sb.size() == 0) begin
                    chk("beat_unexpected", st_data, 64'hDEAD_0000);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", st_data, e.data);
                    chk("beat_sop", st_startofpacket, e.sop);
                    chk("beat_eop", st_endofpacket, e.eop);
                    if (e.cyc >= 0) chk("beat_cycle", cyc, e.cyc);
                end
            end
            if (rd_cnt - beat_cnt > max_out) max_out = rd_cnt - beat_cnt;
            if (done) begin
                int d;
                done_cnt++;
                if (done_exp.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    d = done_exp.pop_front();
                    if (d >= 0) chk("done_cycle", cyc, d);
                end
            end
            prev_stall = st_valid && !st_ready;
            prev_data  = st_data;
            prev_sop   = st_startofpacket;
            prev_eop   = st_endofpacket;
        end
    end

    // Returns during cycle 1 of the transfer (cycle 0 is the sampling cycle).
    task automatic do_start(input logic [13:0] a, input logic [14:0] n, input bit timed);
        int t0;
        beat_t e;
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = a;
        length     = n;
        t0         = cyc;
        for (int k = 0; k < int'(n); k++) begin
            e.data = {18'b0, a + 14'(k)};
            e.sop  = (k == 0);
            e.eop  = (k == int'(n) - 1);
            e.cyc  = timed ? t0 + 3 + k : -1;
            sb.push_back(e);
        end
        if (!timed)       done_exp.push_back(-1);
        else if (n == 0)  done_exp.push_back(t0 + 1);
        else              done_exp.push_back(t0 + int'(n) + 3);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input bit toggle);
        for (int i = 0; i < budget && done_cnt < target; i++) begin
            @(posedge clk);
            #1;
            if (toggle) st_ready = ~st_ready;
        end
        chk("done_timeout", done_cnt >= target, 1);
        st_ready = 1'b1;
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_st_valid"}, st_valid, 0);
        chk({tag, "_sop"}, st_startofpacket, 0);
        chk({tag, "_eop"}, st_endofpacket, 0);
        chk({tag, "_cs"}, mem_chipselect, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_st_data"}, st_data, 0);
    endtask

    initial begin
        int r0, v0, d0;
        for (int i = 0; i < 16384; i++) mem[i] = i;
        mem_readdata = '0;
        reset_n    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        st_ready   = 1'b1;
        #2;
        chk_reset_outputs("rst");
        chk("tie_write", mem_write, 0);
        chk("tie_be", mem_byteenable, 4'hF);
        chk("tie_clken", mem_clken, 1);
        #20;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // 8 words from 0x10 with st_ready high: beats in cycles 3..10, done in 11
        do_start(14'h0010, 15'd8, 1'b1);
        @(negedge clk);
        chk("c1_busy", busy, 1);
        chk("c1_cs", mem_chipselect, 1);
        chk("c1_addr", mem_address, 14'h0010);
        wait_done(1, 100, 1'b0);

        // address wrap 3FFE, 3FFF, 0000, 0001
        do_start(14'h3FFE, 15'd4, 1'b1);
        wait_done(2, 100, 1'b0);

        // zero length: done in cycle 1 only
        r0 = rd_cnt; v0 = val_cnt;
        do_start(14'h0020, 15'd0, 1'b1);
        @(negedge clk);
        chk("len0_busy", busy, 0);
        chk("len0_cs", mem_chipselect, 0);
        wait_done(3, 20, 1'b0);
        repeat (5) @(posedge clk);
        chk("len0_reads", rd_cnt - r0, 0);
        chk("len0_valid", val_cnt - v0, 0);

        // 16 words with st_ready toggling
        max_out = 0;
        do_start(14'h0040, 15'd16, 1'b0);
        wait_done(4, 200, 1'b1);
        chk("toggle_credit", max_out <= 4, 1);

        // 10 words with st_ready low for 20 cycles
        max_out = 0;
        st_ready = 1'b0;
        r0 = rd_cnt;
        do_start(14'h0080, 15'd10, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        chk("stall_reads", rd_cnt - r0, 4);
        chk("stall_cs_low", mem_chipselect, 0);
        chk("stall_max_out", max_out, 4);
        st_ready = 1'b1;
        wait_done(5, 100, 1'b0);
        chk("stall_total_reads", rd_cnt - r0, 10);

        // second start while busy is dropped
        r0 = rd_cnt;
        do_start(14'h0100, 15'd6, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 14'h0200; length = 15'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(6, 100, 1'b0);
        repeat (6) @(posedge clk);
        chk("dbl_reads", rd_cnt - r0, 6);
        chk("dbl_done_count", done_cnt, 6);

        // reset in cycle 5 of a length-8 transfer
        d0 = done_cnt;
        do_start(14'h0300, 15'd8, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        chk("midrst_beats_before", sb.size(), 6);
        sb.delete();
        done_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("midrst_no_done", done_cnt, d0);
        do_start(14'h1234, 15'd5, 1'b1);
        @(negedge clk);
        chk("post_rst_addr", mem_address, 14'h1234);
        wait_done(d0 + 1, 100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nioslab2_mem_stream_reader.md
# niosLab2_mem_stream_reader

Avalon-MM read master that streams a block of words out of the niosLab2 on-chip memory. On a start command it issues sequential single-word reads to the memory's s2 slave port and forwards the returned words on an Avalon-ST source with backpressure. It sits directly upstream of the downstream stream consumers and downstream of the on-chip RAM. Software fills the RAM through s1 and then triggers a transfer through this block.

## Interface
- ADDR_W, 14, word address width; matches memory depth 16384
- DATA_W, 32, data width
- FIFO_DEPTH, 4, output buffer entries; power of two, ≥ 2
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset; asynchronous assert, active-low
- start  in  1  one-cycle command pulse; ignored while busy
- start_addr  in  ADDR_W  first word address
- length  in  ADDR_W+1  word count, 0..16384
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- mem_address  out  ADDR_W  word address to RAM
- mem_chipselect  out  1  read strobe
- mem_write  out  1  constant 0
- mem_byteenable  out  4  constant 4'hF
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  RAM data; valid exactly 1 cycle after the strobe
- st_data  out  DATA_W  stream data
- st_valid  out  1  stream valid
- st_ready  in  1  stream ready
- st_startofpacket  out  1  first word of transfer
- st_endofpacket  out  1  last word of transfer

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE + start, length≠0: latch the address and length, then go to RUN. busy rises the next cycle.
- IDLE + start, length=0: pulse done the next cycle, stay in IDLE, and emit no beats.
- RUN: issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is 0 or 1: a read issued in the previous cycle.
  - The address increments by 1 per read, modulo 2^ADDR_W; 16383 wraps to 0.
- RUN → DRAIN in the cycle after the read with index length-1 is issued.
- DRAIN → IDLE when inflight=0, the FIFO is empty, and the last beat handshake has completed. done pulses in that cycle and busy falls in the same cycle.
- Returned data is written into the FIFO unconditionally; the credit rule guarantees the FIFO never overflows.
- A beat transfers when st_valid & st_ready. Output order equals address order.
- st_startofpacket is high with beat 0. st_endofpacket is high with beat length-1. For length=1 both are high on the same beat.
- st_data, st_valid, st_startofpacket and st_endofpacket hold stable while st_valid & ~st_ready.
- A start pulse while busy is dropped and has no side effects.
- Reset mid-transfer clears the FSM, counters and FIFO; the read in flight is discarded.
- Reset values: busy=0, done=0, st_valid=0, st_startofpacket=0, st_endofpacket=0, mem_chipselect=0, mem_address=0, st_data=0.

## Timing
- Cycle 0: start is sampled.
- Cycle 1: busy=1; the first mem_chipselect with mem_address=start_addr.
- Cycle 2: mem_readdata is captured into the FIFO.
- Cycle 3: st_valid=1 with beat 0.
- Latency from start to the first beat is 3 cycles.
- With st_ready held high, throughput is 1 beat/cycle. A length-N transfer's last beat is in cycle N+2 and done is in cycle N+3.
- After st_ready deasserts, at most FIFO_DEPTH beats are buffered. Reads resume 1 cycle after a FIFO slot frees.
- A new start is accepted in the cycle after done.

## Structure
- Package niosLab2_mem_pkg:
  - ADDR_W and DATA_W defaults
  - the FSM state enum {IDLE, RUN, DRAIN}
  - the constants MEM_BE_ALL=4'hF and MEM_RD_LATENCY=1
- Sub-module niosLab2_stream_fifo: synchronous FIFO, FIFO_DEPTH × (DATA_W+2) carrying data, sop and eop, with count output. It uses the same clk/reset_n.
- The top level holds the FSM, address and issue counters, the inflight flag and the constant tie-offs.

## Test plan
- Memory preloaded with word[i]=i; start_addr=0x0010, length=8, st_ready=1:
  - beats 0x10..0x17 appear in cycles 3..10
  - sop on 0x10, eop on 0x17
  - done in cycle 11
- start_addr=0x3FFE, length=4 → reads at addresses 3FFE, 3FFF, 0000, 0001; beats in that order.
- length=0 → done pulses in cycle 1, busy stays 0, no chipselect, no st_valid.
- length=16, st_ready toggling 1/0 each cycle:
  - all 16 beats delivered in order
  - data stable while stalled
  - fifo_count never exceeds 4
  - no beat lost
- length=10, st_ready=0 for 20 cycles then 1:
  - exactly 4 reads issued, then chipselect stays low
  - after release all 10 beats complete
- Mid-transfer checks:
  - a second start during busy is ignored and the first transfer completes unchanged
  - reset_n low in cycle 5 of a length-8 transfer drives all outputs to their reset values at once
  - the next start after reset runs cleanly from its own start_addr
